// File: rtl/hsmc_lane_pkg.sv
// Shared types for the HSMC lane receiver: FSM states, symbol classes, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hsmc_lane_pkg;

  localparam int LANE_W = 4;

  // Receiver phase tracking state
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_P    = 2'd1,
    S_N    = 2'd2,
    S_Z    = 2'd3
  } state_e;

  // Class of an accepted (stable) lane symbol
  typedef enum logic [1:0] {
    SP = 2'd0,   // p nonzero, n zero
    SN = 2'd1,   // p zero, n nonzero
    SZ = 2'd2,   // both zero
    SC = 2'd3    // both nonzero (collision)
  } sym_e;

endpackage

// File: rtl/hsmc_lane_filter.sv
// Synchronises both lane groups, accepts a symbol after STABLE_CYCLES identical samples, classifies it.
// Latency: 2 + STABLE_CYCLES clocks from pin change to the one-cycle evt strobe.
// Backpressure: none; free-running, the strobe is never held off.
module hsmc_lane_filter
  import hsmc_lane_pkg::*;
#(
  parameter int W             = LANE_W,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] lane_p,
  input  logic [W-1:0] lane_n,
  output logic         evt,
  output sym_e         sym,
  output logic [W-1:0] word
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [W-1:0]   p_meta_q, p_meta_d, p_sync_q, p_sync_d;
  logic [W-1:0]   n_meta_q, n_meta_d, n_sync_q, n_sync_d;
  logic [2*W-1:0] prev_q, prev_d;
  logic [CW-1:0]  stab_cnt_q, stab_cnt_d;
  logic [W-1:0]   pv, nv;

  // Two-flop synchroniser and run-length counter of identical synchronised samples
  always_comb begin
    p_meta_d = lane_p;
    p_sync_d = p_meta_q;
    n_meta_d = lane_n;
    n_sync_d = n_meta_q;
    prev_d   = {p_sync_q, n_sync_q};
    if ({p_sync_q, n_sync_q} != prev_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != CW'(STABLE_CYCLES)) begin
      // Saturate one past the strobe value so the strobe fires only once per symbol
      stab_cnt_d = stab_cnt_q + CW'(1);
    end else begin
      stab_cnt_d = stab_cnt_q;
    end
  end

  // State registers for the input path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_meta_q   <= '0;
      p_sync_q   <= '0;
      n_meta_q   <= '0;
      n_sync_q   <= '0;
      prev_q     <= '0;
      stab_cnt_q <= '0;
    end else begin
      p_meta_q   <= p_meta_d;
      p_sync_q   <= p_sync_d;
      n_meta_q   <= n_meta_d;
      n_sync_q   <= n_sync_d;
      prev_q     <= prev_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  // prev_q holds the value the counter has been qualifying
  assign pv  = prev_q[2*W-1:W];
  assign nv  = prev_q[W-1:0];
  assign evt = (stab_cnt_q == CW'(STABLE_CYCLES - 1));

  // Classify the stable symbol and pick the data-carrying group
  always_comb begin
    sym  = SZ;
    word = '0;
    if (pv != '0 && nv != '0) begin
      sym  = SC;
      word = pv;
    end else if (pv != '0) begin
      sym  = SP;
      word = pv;
    end else if (nv != '0) begin
      sym  = SN;
      word = nv;
    end
  end

endmodule

// File: rtl/hsmc_lane_rx.sv
// HSMC 4-lane pseudo-differential receiver: P/N phase FSM, data compare, lock, phase length, timeout.
// Latency: outputs register one clock after the filter strobe (3 + STABLE_CYCLES clocks after a pin change).
// Backpressure: none; status pulses are single-cycle and unacknowledged. Optional stats: HSMC_RX_STATS_EN.
module hsmc_lane_rx
  import hsmc_lane_pkg::*;
#(
  parameter int          W             = LANE_W,
  parameter int          STABLE_CYCLES = 4,
  parameter int          CNT_W         = 24,
  parameter int unsigned TIMEOUT       = 24'hFF_FFFF
) (
  input  logic             OSC_50_B8A,
  input  logic             RESET_n,
  input  logic [W-1:0]     HSMC_RX_p,
  input  logic [W-1:0]     HSMC_RX_n,
  output logic [W-1:0]     rx_data,
  output logic             rx_valid,
  output logic             rx_err,
  output logic             rx_lock,
  output logic [CNT_W-1:0] phase_len,
  output logic             phase_len_valid
`ifdef HSMC_RX_STATS_EN
  ,
  output logic [7:0]       err_count,
  output logic [7:0]       lock_loss
`endif
);

  logic         evt;
  sym_e         sym;
  logic [W-1:0] word;

  hsmc_lane_filter #(
    .W             (W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk    (OSC_50_B8A),
    .rst_n  (RESET_n),
    .lane_p (HSMC_RX_p),
    .lane_n (HSMC_RX_n),
    .evt    (evt),
    .sym    (sym),
    .word   (word)
  );

  state_e           state_q, state_d;
  state_e           own_st, partner_st;
  logic [W-1:0]     held_q, held_d;
  logic [W-1:0]     rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_err_q, rx_err_d;
  logic             rx_lock_q, rx_lock_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] phase_len_q, phase_len_d;
  logic             plen_vld_q, plen_vld_d;

  // Phase FSM, data compare, phase-length counter and timeout; an event beats a timeout
  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_err_d    = 1'b0;
    rx_lock_d   = rx_lock_q;
    phase_len_d = phase_len_q;
    plen_vld_d  = 1'b0;
    own_st      = (sym == SP) ? S_P : S_N;
    partner_st  = (sym == SP) ? S_N : S_P;
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    if (evt) begin
      cnt_d = CNT_W'(1);
      // Coming out of idle there is no meaningful previous phase to measure
      if (state_q != S_IDLE) begin
        phase_len_d = cnt_q;
        plen_vld_d  = 1'b1;
      end
      unique case (sym)
        SP, SN: begin
          if (state_q == partner_st) begin
            if (word == held_q) begin
              rx_valid_d = 1'b1;
              rx_data_d  = word;
              rx_lock_d  = 1'b1;
            end else begin
              // Expected once after every data change; the next pair re-locks
              rx_err_d  = 1'b1;
              rx_lock_d = 1'b0;
              held_d    = word;
            end
          end else begin
            held_d = word;
          end
          state_d = own_st;
        end
        SZ: begin
          // Zero looks the same in both phases, so lock is left alone
          if (state_q != S_Z) begin
            rx_data_d  = '0;
            rx_valid_d = 1'b1;
          end
          held_d  = '0;
          state_d = S_Z;
        end
        SC: begin
          rx_err_d  = 1'b1;
          rx_lock_d = 1'b0;
          state_d   = S_IDLE;
        end
      endcase
    end else if ((state_q == S_P || state_q == S_N) && cnt_q >= CNT_W'(TIMEOUT)) begin
      state_d   = S_IDLE;
      rx_lock_d = 1'b0;
    end
  end

  // Core state registers
  always_ff @(posedge OSC_50_B8A or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= S_IDLE;
      held_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_lock_q   <= 1'b0;
      cnt_q       <= '0;
      phase_len_q <= '0;
      plen_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      rx_lock_q   <= rx_lock_d;
      cnt_q       <= cnt_d;
      phase_len_q <= phase_len_d;
      plen_vld_q  <= plen_vld_d;
    end
  end

  assign rx_data         = rx_data_q;
  assign rx_valid        = rx_valid_q;
  assign rx_err          = rx_err_q;
  assign rx_lock         = rx_lock_q;
  assign phase_len       = phase_len_q;
  assign phase_len_valid = plen_vld_q;

`ifdef HSMC_RX_STATS_EN
  logic [7:0] err_count_q, err_count_d;
  logic [7:0] lock_loss_q, lock_loss_d;

  // Saturating error and lock-loss counters
  always_comb begin
    err_count_d = err_count_q;
    lock_loss_d = lock_loss_q;
    if (rx_err_d && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end
    if (rx_lock_q && !rx_lock_d && lock_loss_q != 8'hFF) begin
      lock_loss_d = lock_loss_q + 8'd1;
    end
  end

  // Stats registers
  always_ff @(posedge OSC_50_B8A or negedge RESET_n) begin
    if (!RESET_n) begin
      err_count_q <= '0;
      lock_loss_q <= '0;
    end else begin
      err_count_q <= err_count_d;
      lock_loss_q <= lock_loss_d;
    end
  end

  assign err_count = err_count_q;
  assign lock_loss = lock_loss_q;
`endif

endmodule

// File: tb/tb_hsmc_lane_rx.sv
// Randomised bench for hsmc_lane_rx against a cycle-count reference model of the link rules.
// Latency: model results are compared four clocks after the pin value that produced them is driven.
// Backpressure: n/a.
module tb_hsmc_lane_rx;

  localparam int W       = 4;
  localparam int STAB    = 4;
  localparam int CNT_W   = 24;
  localparam int TMO     = 100;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [W-1:0]     HSMC_RX_p;
  logic [W-1:0]     HSMC_RX_n;
  logic [W-1:0]     rx_data;
  logic             rx_valid;
  logic             rx_err;
  logic             rx_lock;
  logic [CNT_W-1:0] phase_len;
  logic             phase_len_valid;
`ifdef HSMC_RX_STATS_EN
  logic [7:0]       err_count;
  logic [7:0]       lock_loss;
`endif

  hsmc_lane_rx #(
    .W             (W),
    .STABLE_CYCLES (STAB),
    .CNT_W         (CNT_W),
    .TIMEOUT       (TMO)
  ) dut (
    .OSC_50_B8A      (clk),
    .RESET_n         (rst_n),
    .HSMC_RX_p       (HSMC_RX_p),
    .HSMC_RX_n       (HSMC_RX_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_err          (rx_err),
    .rx_lock         (rx_lock),
    .phase_len       (phase_len),
    .phase_len_valid (phase_len_valid)
`ifdef HSMC_RX_STATS_EN
    ,
    .err_count       (err_count),
    .lock_loss       (lock_loss)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         valid;
    logic         err;
    logic         lock;
    int           plen;
    logic         plv;
    int           ec;
    int           ll;
  } exp_t;

  exp_t expq[$];

  // Model phase: 0 idle, 1 P, 2 N, 3 zero
  int           m_phase;
  logic [7:0]   m_last;
  int           m_run;
  logic [W-1:0] m_held;
  logic [W-1:0] m_data;
  logic         m_lock;
  int           m_plen;
  int           m_cnt;
  int           m_ec;
  int           m_ll;

  task automatic model_reset();
    exp_t z;
    m_phase = 0;
    // Synchroniser and history flops reset to zero count as three zero samples already seen
    m_last  = '0;
    m_run   = 3;
    m_held  = '0;
    m_data  = '0;
    m_lock  = 1'b0;
    m_plen  = 0;
    m_cnt   = 3;
    m_ec    = 0;
    m_ll    = 0;
    z = '{data: '0, valid: 1'b0, err: 1'b0, lock: 1'b0, plen: 0, plv: 1'b0, ec: 0, ll: 0};
    expq.delete();
    repeat (3) expq.push_back(z);
  endtask

  task automatic model_step(input logic [W-1:0] p, input logic [W-1:0] n);
    exp_t e;
    logic ev, v_pls, e_pls, pl_pls, was_lock;
    int   tgt, partner;
    v_pls = 1'b0; e_pls = 1'b0; pl_pls = 1'b0;
    was_lock = m_lock;
    if ({p, n} == m_last) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_last = {p, n};
      m_run  = 1;
    end
    ev = (m_run == STAB);
    if (ev) begin
      if (m_phase != 0) begin
        m_plen = m_cnt;
        pl_pls = 1'b1;
      end
      m_cnt = 1;
      if (p != 0 && n != 0) begin
        e_pls   = 1'b1;
        m_lock  = 1'b0;
        m_phase = 0;
      end else if (p == 0 && n == 0) begin
        if (m_phase != 3) begin
          m_data = '0;
          v_pls  = 1'b1;
        end
        m_held  = '0;
        m_phase = 3;
      end else begin
        tgt     = (p != 0) ? 1 : 2;
        partner = (p != 0) ? 2 : 1;
        if (m_phase == partner && ((p | n) == m_held)) begin
          v_pls  = 1'b1;
          m_data = p | n;
          m_lock = 1'b1;
        end else if (m_phase == partner) begin
          e_pls  = 1'b1;
          m_lock = 1'b0;
          m_held = p | n;
        end else begin
          m_held = p | n;
        end
        m_phase = tgt;
      end
    end else begin
      if ((m_phase == 1 || m_phase == 2) && m_cnt >= TMO) begin
        m_phase = 0;
        m_lock  = 1'b0;
      end
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    if (e_pls && m_ec < 255) m_ec++;
    if (was_lock && !m_lock && m_ll < 255) m_ll++;
    e = '{data: m_data, valid: v_pls, err: e_pls, lock: m_lock, plen: m_plen, plv: pl_pls, ec: m_ec, ll: m_ll};
    expq.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    check_val("rx_data", 32'(rx_data), 32'(e.data));
    check_val("rx_valid", 32'(rx_valid), 32'(e.valid));
    check_val("rx_err", 32'(rx_err), 32'(e.err));
    check_val("rx_lock", 32'(rx_lock), 32'(e.lock));
    check_val("phase_len", 32'(phase_len), 32'(e.plen));
    check_val("phase_len_valid", 32'(phase_len_valid), 32'(e.plv));
`ifdef HSMC_RX_STATS_EN
    check_val("err_count", 32'(err_count), 32'(e.ec));
    check_val("lock_loss", 32'(lock_loss), 32'(e.ll));
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  // Called one time unit after a rising edge
  task automatic tick(input logic [W-1:0] p, input logic [W-1:0] n);
    exp_t e;
    HSMC_RX_p = p;
    HSMC_RX_n = n;
    model_step(p, n);
    @(posedge clk);
    #1;
    e = expq.pop_front();
    compare(e);
  endtask

  task automatic phase(input logic [W-1:0] p, input logic [W-1:0] n, input int len);
    for (int i = 0; i < len; i++) tick(p, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_rx_data", 32'(rx_data), 32'd0);
    check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_val("rst_rx_err", 32'(rx_err), 32'd0);
    check_val("rst_rx_lock", 32'(rx_lock), 32'd0);
    check_val("rst_phase_len", 32'(phase_len), 32'd0);
    check_val("rst_plen_valid", 32'(phase_len_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] w, a, b;
    int kind, len;
    rst_n     = 1'b0;
    HSMC_RX_p = '0;
    HSMC_RX_n = '0;
    w         = 4'h5;
    @(posedge clk);
    #1;
    do_reset();

    // Matching P/N pair locks on 5 with a 40-clock phase
    phase(4'h5, 4'h0, 40);
    phase(4'h0, 4'h5, 40);
    check_val("pair5_data", 32'(rx_data), 32'h5);
    check_val("pair5_lock", 32'(rx_lock), 32'd1);
    check_val("pair5_plen", 32'(phase_len), 32'd40);

    // Data change: one error at P, re-lock at N
    phase(4'h6, 4'h0, 40);
    check_val("chg_lock_drop", 32'(rx_lock), 32'd0);
    phase(4'h0, 4'h6, 40);
    check_val("chg_data", 32'(rx_data), 32'h6);
    check_val("chg_lock", 32'(rx_lock), 32'd1);

    // Collision drops lock
    phase(4'h3, 4'h3, 20);
    check_val("coll_lock", 32'(rx_lock), 32'd0);

    // Short glitches around an idle zero line
    phase(4'h0, 4'h0, 20);
    phase(4'h5, 4'h0, 3);
    phase(4'h0, 4'h0, 10);
    phase(4'h0, 4'h9, 2);
    phase(4'h0, 4'h0, 10);
    check_val("glitch_data", 32'(rx_data), 32'h0);
    check_val("glitch_lock", 32'(rx_lock), 32'd0);

    // Lock then hold P past the timeout
    phase(4'h5, 4'h0, 40);
    phase(4'h0, 4'h5, 40);
    check_val("tmo_pre_lock", 32'(rx_lock), 32'd1);
    phase(4'h5, 4'h0, 150);
    check_val("tmo_lock", 32'(rx_lock), 32'd0);

    // Reset in the middle of a phase
    phase(4'h0, 4'h5, 20);
    do_reset();
    phase(4'h0, 4'h5, 30);
    phase(4'h5, 4'h0, 30);

    // Randomised traffic
    for (int s = 0; s < 250; s++) begin
      kind = int'($urandom_range(0, 19));
      len  = int'($urandom_range(4, 50));
      if (kind == 0) begin
        do_reset();
      end else if (kind <= 10) begin
        if ($urandom_range(0, 2) == 0) w = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 1) == 0) begin
          phase(w, 4'h0, len);
          phase(4'h0, w, len);
        end else begin
          phase(4'h0, w, len);
          phase(w, 4'h0, len);
        end
      end else if (kind <= 12) begin
        phase(4'h0, 4'h0, len);
      end else if (kind <= 14) begin
        a = 4'($urandom_range(1, 15));
        b = 4'($urandom_range(1, 15));
        phase(a, b, len);
      end else if (kind <= 17) begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        phase(a, b, int'($urandom_range(1, 3)));
      end else begin
        phase(w, 4'h0, int'($urandom_range(95, 130)));
      end
    end

`ifdef HSMC_RX_STATS_EN
    // Many collision events saturate the error counter
    for (int i = 0; i < 150; i++) begin
      phase(4'h3, 4'h3, 5);
      phase(4'h5, 4'h9, 5);
    end
    check_val("err_count_sat", 32'(err_count), 32'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
